uart_rx_os16: RTL and testbench
===============================

# uart_rx_os16

Oversampling UART receiver for frames paced by the shared `baud16_en` strobe (16 strobes per bit): 8N1, LSB first. It sits in `uart_core` as the receiving end for a baud-rate transmitter on the `uart_core` serial pins, with these functions:
- mid-bit sampling
- start-glitch rejection
- framing-error detection
- a one-byte holding register with ack handshake and overrun flag

Its `rx_frame_err` output drives the `rx_error` output of `uart_core`.

## Interface
- `SYNC_STAGES`, default 2: number of input synchronizer flops on `rx_in`; legal range is 2 or more.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `baud16_en` in 1: one-`clk` strobe at 16× baud. Held at 1 when a single `clk` per tick is wanted.
- `rx_in` in 1: serial line, asynchronous; idle level is 1.
- `rx_ack` in 1: consumer acknowledge; clears `rx_valid`.
- `rx_data` out 8: last good received byte.
- `rx_valid` out 1: `rx_data` holds an unread byte; level signal.
- `rx_frame_err` out 1: one-`clk` pulse when the stop bit is sampled as 0.
- `rx_overrun` out 1: one-`clk` pulse when a good byte lands while `rx_valid`=1 without `rx_ack`.
- `rx_busy` out 1: state machine is not in IDLE.

## Operation
- **Synchronizer:** `rx_in` passes through `SYNC_STAGES` flops, all reset to 1. All logic below uses the synchronized value `rxs`.
- **Tick counter and bit index:**
  - `tcnt` is 4 bits and advances only on `baud16_en`.
  - `bidx` is 3 bits.
- **State IDLE:**
  - On `baud16_en` with `rxs`=0: go to START and set `tcnt`=0.
- **State START:**
  - On each `baud16_en`, `tcnt` increments.
  - When `tcnt`=7 on a tick, sample `rxs` (mid start bit).
  - If the sample is 0: go to DATA with `tcnt`=0 and `bidx`=0.
  - If the sample is 1: return to IDLE as a glitch. No flag is raised.
- **State DATA:**
  - On the tick where `tcnt`=15, sample `rxs` into shift register bit `bidx` (LSB first). That tick also wraps `tcnt` to 0.
  - If `bidx`=7: go to STOP. Otherwise `bidx` increments.
- **State STOP:**
  - On the tick where `tcnt`=15, sample `rxs`.
  - If the sample is 1 (good frame): load `rx_data` from the shift register, set `rx_valid`, go to IDLE.
  - If the sample is 0: pulse `rx_frame_err`, leave `rx_data` and `rx_valid` untouched, go to BREAK.
- **State BREAK:**
  - On `baud16_en` with `rxs`=1: go to IDLE.
  - This prevents a held-low line from being re-read as a start bit.
- **Holding register:**
  - `rx_ack`=1 clears `rx_valid` on the next edge.
  - If a good frame completes while `rx_valid`=1 and `rx_ack`=0: `rx_data` is overwritten with the new byte, `rx_valid` stays 1, and `rx_overrun` pulses.
  - If a good frame completes in the same cycle as `rx_ack`=1: the new byte loads, `rx_valid` stays 1, no overrun.
  - `rx_ack` while `rx_valid`=0 is ignored.
- **Tick gating:** With `baud16_en`=0 the FSM and `tcnt` hold. Synchronizer flops and `rx_ack` handling still run every `clk`.

## Timing
- **Reset values:**
  - `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_busy`=0.
  - State IDLE, `tcnt`=0, `bidx`=0, synchronizer=all 1.
- **Reset mid-frame:** aborts immediately. The partial byte is discarded and no flags are raised after release.
- **Input delay:** a `rx_in` edge reaches `rxs` after `SYNC_STAGES` `clk` edges.
- **Sampling ticks**, counting the tick at which START is entered as tick 0:
  - start bit sampled at tick 8;
  - data bit *i* sampled at tick 8+16(*i*+1);
  - stop bit sampled at tick 152.
- **Output latency:**
  - `rx_valid` rises, and `rx_data` updates, on the `clk` edge of the stop-sample tick.
  - `rx_frame_err` and `rx_overrun` are high for exactly the one `clk` following that edge.
- **`rx_busy`:** high from the edge entering START until the edge returning to IDLE, BREAK included.
- **Back-to-back frames:** a start bit immediately after a good stop is detected on the first tick in IDLE. IDLE needs no extra idle time.
- **Tolerance:** with `baud16_en`=1 and 16 `clk`/bit, ±3 ticks of accumulated skew by the stop bit still samples correctly.

## Test plan
- **Good frame:** `baud16_en`=1; drive 0xA5 as 8N1 at 16 `clk`/bit (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → `rx_data`=0xA5 and `rx_valid`=1 at tick 152 after START entry; `rx_frame_err`=0; `rx_ack` pulse → `rx_valid`=0 next edge.
- **Glitch rejection:** `rx_in` low for 4 `clk` then high → START entered, returns to IDLE at tick 8; `rx_valid`, `rx_frame_err` and `rx_overrun` all stay 0; `rx_busy` low again.
- **Framing error and BREAK:** frame 0x3C with stop bit 0, line held low 40 `clk`, then high; then frame 0x81 →
  - `rx_frame_err` one-cycle pulse; `rx_data` unchanged; no valid;
  - BREAK held until the line goes high;
  - then `rx_data`=0x81, `rx_valid`=1.
- **Overrun and ack collision:**
  - send 0x11 then 0x22 with no ack → `rx_overrun` pulse at the second stop sample, `rx_data`=0x22, `rx_valid`=1;
  - send 0x33 with `rx_ack` asserted exactly at its stop-sample edge → `rx_data`=0x33, `rx_valid`=1, no overrun.
- **Tick gating:** `baud16_en` high 1-in-4 `clk`, frame at 64 `clk`/bit with 0x5A → `rx_data`=0x5A, `rx_valid`=1.
- **Reset mid-frame:** `rst_n`=0 after data bit 3 of 0xFF → all outputs at reset values. After release, a fresh 0x0F frame is received correctly.

Source files
------------

// File: rtl/uart_rx_os16.sv
// 8N1 oversampling UART receiver (16 baud16_en ticks per bit, mid-bit sampling, glitch/framing checks).
// Latency: rx_valid/rx_data update on the stop-sample tick; no backpressure, an unread byte is overwritten with rx_overrun.
module uart_rx_os16 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud16_en,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [2:0]             state;
  logic [3:0]             tcnt;
  logic [2:0]             bidx;
  logic [7:0]             shreg;
  logic                   stop_tick;
  logic                   good_stop;
  logic                   bad_stop;

  // Synchronizer resets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  assign stop_tick = baud16_en && (state == ST_STOP) && (tcnt == 4'd15);
  assign good_stop = stop_tick && rxs;
  assign bad_stop  = stop_tick && !rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tcnt  <= 4'd0;
      bidx  <= 3'd0;
      shreg <= 8'h00;
    end else if (baud16_en) begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            tcnt  <= 4'd0;
          end
        end
        ST_START: begin
          // Mid start bit: a high line here was only a glitch.
          if (tcnt == 4'd7) begin
            tcnt  <= 4'd0;
            bidx  <= 3'd0;
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        ST_DATA: begin
          if (tcnt == 4'd15) begin
            shreg[bidx] <= rxs;
            tcnt        <= 4'd0;
            if (bidx == 3'd7) begin
              bidx  <= 3'd0;
              state <= ST_STOP;
            end else begin
              bidx <= bidx + 3'd1;
            end
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        ST_STOP: begin
          if (tcnt == 4'd15) begin
            tcnt  <= 4'd0;
            state <= rxs ? ST_IDLE : ST_BREAK;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        ST_BREAK: begin
          // Wait for mark so a held-low line is not taken as a new start bit.
          if (rxs) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          tcnt  <= 4'd0;
          bidx  <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= bad_stop;
      rx_overrun   <= good_stop && rx_valid && !rx_ack;
      // A new byte wins over a same-cycle ack, so valid stays set.
      if (good_stop) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: 8N1 frames driven bit by bit, expectations hand-computed.
module tb_uart_rx_os16;

  logic       clk;
  logic       rst_n;
  logic       baud16_en;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gate_div = 1;
  int start_cyc = 0;

  int   fe_cnt = 0;
  int   ov_cnt = 0;
  bit   fe_wide = 1'b0;
  bit   ov_wide = 1'b0;
  int   busy_rise_cyc = -1;
  int   busy_fall_cyc = -1;
  int   valid_rise_cyc = -1;
  logic prev_fe = 1'b0;
  logic prev_ov = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_valid = 1'b0;

  uart_rx_os16 #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud16_en    (baud16_en),
    .rx_in        (rx_in),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick strobe: every clk when gate_div is 1, else one clk in gate_div.
  initial begin
    int ph;
    ph = 0;
    baud16_en = 1'b1;
    forever begin
      @(negedge clk);
      baud16_en = (gate_div <= 1) || (ph == 0);
      ph = (gate_div <= 1) ? 0 : (ph + 1) % gate_div;
    end
  end

  // Event recorder, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rx_frame_err) begin
      fe_cnt = fe_cnt + 1;
      if (prev_fe) fe_wide = 1'b1;
    end
    if (rx_overrun) begin
      ov_cnt = ov_cnt + 1;
      if (prev_ov) ov_wide = 1'b1;
    end
    if (rx_busy && !prev_busy) busy_rise_cyc = cyc;
    if (!rx_busy && prev_busy) busy_fall_cyc = cyc;
    if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_fe    = rx_frame_err;
    prev_ov    = rx_overrun;
    prev_busy  = rx_busy;
    prev_valid = rx_valid;
  end

  // Called at a falling edge; drives start, 8 data bits LSB first, stop. rx_ack pulses when cyc == ack_cyc.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int cpb, input int ack_cyc);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    start_cyc = cyc;
    for (int b = 0; b < 10; b++) begin
      rx_in = bits[b];
      for (int k = 0; k < cpb; k++) begin
        rx_ack = (cyc == ack_cyc);
        @(negedge clk);
      end
    end
    rx_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_in: got %h want 000", {rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if ({rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_idle: got %h want 000", {rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy});
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b1, 16, -1);
    n_vec++;
    if (busy_rise_cyc != start_cyc + 3) begin
      n_err++;
      $display("FAIL good_start_entry: got cyc %0d want %0d", busy_rise_cyc, start_cyc + 3);
    end
    n_vec++;
    if (valid_rise_cyc != start_cyc + 3 + 152) begin
      n_err++;
      $display("FAIL good_valid_tick: got cyc %0d want %0d", valid_rise_cyc, start_cyc + 155);
    end
    n_vec++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL good_data: got %h/%b want a5/1", rx_data, rx_valid);
    end
    n_vec++;
    if (fe_cnt != 0 || rx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL good_flags: got fe=%0d busy=%b want 0/0", fe_cnt, rx_busy);
    end
    pulse_ack();
    n_vec++;
    if (rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL good_ack: got valid %b want 0", rx_valid);
    end
    pulse_ack();
    @(negedge clk);
    n_vec++;
    if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
      n_err++;
      $display("FAIL idle_ack: got %h/%b want a5/0", rx_data, rx_valid);
    end
  endtask

  task automatic test_glitch();
    int st;
    st = cyc;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    n_vec++;
    if (busy_rise_cyc != st + 3) begin
      n_err++;
      $display("FAIL glitch_start: got cyc %0d want %0d", busy_rise_cyc, st + 3);
    end
    n_vec++;
    if (busy_fall_cyc != st + 11) begin
      n_err++;
      $display("FAIL glitch_return: got cyc %0d want %0d", busy_fall_cyc, st + 11);
    end
    n_vec++;
    if ({rx_valid, rx_busy} !== 2'b00 || fe_cnt != 0 || ov_cnt != 0) begin
      n_err++;
      $display("FAIL glitch_flags: got valid=%b busy=%b fe=%0d ov=%0d want all 0", rx_valid, rx_busy, fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 16, -1);
    repeat (40) @(negedge clk);
    n_vec++;
    if (fe_cnt != 1 || fe_wide) begin
      n_err++;
      $display("FAIL ferr_pulse: got count=%0d wide=%b want 1/0", fe_cnt, fe_wide);
    end
    n_vec++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_hold: got %h/%b want a5/0", rx_data, rx_valid);
    end
    n_vec++;
    if (rx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL ferr_break: got busy %b want 1", rx_busy);
    end
    rx_in = 1'b1;
    repeat (8) @(negedge clk);
    n_vec++;
    if (rx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL break_exit: got busy %b want 0", rx_busy);
    end
    send_frame(8'h81, 1'b1, 16, -1);
    repeat (4) @(negedge clk);
    n_vec++;
    if (rx_data !== 8'h81 || rx_valid !== 1'b1 || fe_cnt != 1) begin
      n_err++;
      $display("FAIL after_break: got %h/%b fe=%0d want 81/1 fe=1", rx_data, rx_valid, fe_cnt);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    ov_cnt = 0;
    send_frame(8'h11, 1'b1, 16, -1);
    send_frame(8'h22, 1'b1, 16, -1);
    n_vec++;
    if (ov_cnt != 1 || ov_wide) begin
      n_err++;
      $display("FAIL overrun_pulse: got count=%0d wide=%b want 1/0", ov_cnt, ov_wide);
    end
    n_vec++;
    if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_data: got %h/%b want 22/1", rx_data, rx_valid);
    end
    send_frame(8'h33, 1'b1, 16, cyc + 154);
    n_vec++;
    if (rx_data !== 8'h33 || rx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ack_collide_data: got %h/%b want 33/1", rx_data, rx_valid);
    end
    n_vec++;
    if (ov_cnt != 1) begin
      n_err++;
      $display("FAIL ack_collide_ovr: got count %0d want 1", ov_cnt);
    end
    pulse_ack();
  endtask

  task automatic test_gating();
    gate_div = 4;
    @(negedge clk);
    send_frame(8'h5A, 1'b1, 64, -1);
    repeat (8) @(negedge clk);
    gate_div = 1;
    n_vec++;
    if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL gated_data: got %h/%b want 5a/1", rx_data, rx_valid);
    end
    n_vec++;
    if (fe_cnt != 1 || ov_cnt != 1) begin
      n_err++;
      $display("FAIL gated_flags: got fe=%0d ov=%0d want 1/1", fe_cnt, ov_cnt);
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid();
    // Valid is set before the abort so the reset has something to clear.
    send_frame(8'h77, 1'b1, 16, -1);
    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    rx_in = 1'b1;
    repeat (64) @(negedge clk);
    n_vec++;
    if (rx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_busy: got %b want 1", rx_busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy} !== 12'h000) begin
      n_err++;
      $display("FAIL midframe_reset: got %h want 000", {rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fe_cnt = 0;
    ov_cnt = 0;
    repeat (40) @(negedge clk);
    n_vec++;
    if ({rx_valid, rx_busy} !== 2'b00 || fe_cnt != 0 || ov_cnt != 0) begin
      n_err++;
      $display("FAIL post_reset_quiet: got valid=%b busy=%b fe=%0d ov=%0d want all 0", rx_valid, rx_busy, fe_cnt, ov_cnt);
    end
    send_frame(8'h0F, 1'b1, 16, -1);
    n_vec++;
    if (rx_data !== 8'h0F || rx_valid !== 1'b1 || fe_cnt != 0 || ov_cnt != 0) begin
      n_err++;
      $display("FAIL post_reset_frame: got %h/%b fe=%0d ov=%0d want 0f/1 0/0", rx_data, rx_valid, fe_cnt, ov_cnt);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_gating();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
